// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter scheduler.
//   CNT_W : default counter / run-length width
//   N_MAX : largest supported number of requesters
//   state_t : scheduler FSM states
package counter_sched_pkg;

    localparam int CNT_W = 8;
    localparam int N_MAX = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// The request vector is rotated so that ptr_i becomes bit 0.
// The first set bit is found, and its position is rotated back to an absolute index.
// Ports:
//   req_i [N]     : request vector
//   ptr_i [IDX_W] : index with highest priority
//   gnt_o [N]     : one-hot winner, all-zero when no request is set
//   idx_o [IDX_W] : binary index of the winner (0 when no request is set)
//   any_o         : at least one request is set
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [N-1:0] rot;

    always_comb begin
        rot   = '0;
        idx_o = '0;
        any_o = |req_i;
        for (int j = 0; j < N; j++) begin
            rot[j] = req_i[(int'(ptr_i) + j) % N];
        end
        // Scan downwards so the lowest rotated position (closest to ptr) is the one kept.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx_o = IDX_W'((int'(ptr_i) + k) % N);
            end
        end
        gnt_o = any_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/counter_scheduler.sv
// Shares one clear-then-increment counter among N requesters.
// A round-robin arbiter picks a requester and latches its run length.
// The counter runs from 0 up to that length, and then a one-cycle done pulse goes to the owner.
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset
//   req   [N]   : level-sensitive run requests
//   len   [N*W] : run length per requester, slice i = len[i*CNT_W +: CNT_W]
//   abort       : synchronous cancel of the current run
//   busy        : scheduler not idle
//   grant [N]   : one-hot counter owner
//   done  [N]   : one-hot completion pulse
//   count [W]   : current counter value
//
// state | meaning
// IDLE  | no owner, counter holds last value, arbitrate on any request
// RUN   | owner granted, counter increments until it equals the latched length
// DONE  | done pulse to owner for one cycle, grant still asserted
module counter_scheduler #(
    parameter int N     = 4,
    parameter int CNT_W = counter_sched_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N*CNT_W-1:0] len,
    input  logic               abort,
    output logic               busy,
    output logic [N-1:0]       grant,
    output logic [N-1:0]       done,
    output logic [CNT_W-1:0]   count
);

    import counter_sched_pkg::*;

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [N-1:0]       done_q, done_d;
    logic [IDX_W-1:0]   own_q, own_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               busy_q, busy_d;

    logic [N-1:0]       pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   own_next;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Pointer moves past the finished or aborted owner, so that owner has the lowest priority next.
    assign own_next = (own_q == LAST_IDX) ? '0 : own_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        grant_d = grant_q;
        done_d  = '0;
        own_d   = own_q;
        ptr_d   = ptr_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = RUN;
                    grant_d = pick_gnt;
                    own_d   = pick_idx;
                    len_d   = len[pick_idx*CNT_W +: CNT_W];
                    count_d = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = own_next;
                end else if (count_q == len_q) begin
                    state_d = DONE;
                    done_d  = grant_q;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Abort here also returns to IDLE; the pulse is already on its final cycle.
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = own_next;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            len_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign grant = grant_q;
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_counter_scheduler.sv
module tb_counter_scheduler;
    import counter_sched_pkg::*;

    localparam int N = 4;
    localparam int W = CNT_W;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req   = '0;
    logic [N*W-1:0]   len   = '0;
    logic             abort = 1'b0;
    logic             busy;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic [W-1:0]     count;

    counter_scheduler #(.N(N), .CNT_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .abort (abort),
        .busy  (busy),
        .grant (grant),
        .done  (done),
        .count (count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [N-1:0] vec;
        int           at;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Done-pulse scoreboard: every pulse must match the oldest expected entry in vector and cycle.
    always @(negedge clk) begin
        if (reset && done !== '0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got done=%b at cycle %0d, none expected", done, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (done !== e.vec || cyc !== e.at) begin
                    n_err++;
                    $display("FAIL done_pulse: got %b at cycle %0d, want %b at cycle %0d",
                             done, cyc, e.vec, e.at);
                end
            end
        end
    end

    task automatic set_len(input int i, input logic [W-1:0] v);
        len[i*W +: W] = v;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, grant, done} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got busy=%b grant=%b done=%b, want all 0", busy, grant, done);
        end
        n_cmp++;
        if (count !== '0) begin
            n_err++;
            $display("FAIL reset_count: got %0d want 0", count);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    // req[1] alone with len 3: count 0..3, done at T+5, grant gone at T+6.
    task automatic test_single();
        int k;
        set_len(1, 8'd3);
        req = 4'b0010;
        k = cyc;
        exp_q.push_back('{4'b0010, k + 5});
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) req = '0;
            n_cmp++;
            if (grant !== 4'b0010 || busy !== 1'b1 || count !== W'((n < 5) ? n - 1 : 3)) begin
                n_err++;
                $display("FAIL single_run[%0d]: got grant=%b busy=%b count=%0d, want 0010 1 %0d",
                         n, grant, busy, count, (n < 5) ? n - 1 : 3);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (grant !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: got grant=%b busy=%b, want 0000 0", grant, busy);
        end
    endtask

    task automatic test_len_zero();
        int k;
        set_len(2, 8'd0);
        req = 4'b0100;
        k = cyc;
        exp_q.push_back('{4'b0100, k + 2});
        @(negedge clk);
        req = '0;
        n_cmp++;
        if (grant !== 4'b0100 || count !== '0) begin
            n_err++;
            $display("FAIL len_zero_grant: got grant=%b count=%0d, want 0100 0", grant, count);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL len_zero_idle: got busy=%b want 0", busy);
        end
    endtask

    // Owner 3 leaves the stale pointer at 3; after reset req 1100 must go to 2.
    task automatic test_reset_mid_run();
        int  k;
        bit  hit;
        set_len(3, 8'd10);
        req = 4'b1000;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req = '0;
            if (busy === 1'b1 && count === 8'd5) begin
                hit = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL midrun_reach5: got count=%0d, want 5 within 20 cycles", count);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, grant, done} !== '0 || count !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: got busy=%b grant=%b done=%b count=%0d, want all 0",
                     busy, grant, done, count);
        end
        @(negedge clk);
        reset = 1'b1;
        set_len(2, 8'd1);
        set_len(3, 8'd1);
        req = 4'b1100;
        k = cyc;
        exp_q.push_back('{4'b0100, k + 3});
        @(negedge clk);
        req = '0;
        n_cmp++;
        if (grant !== 4'b0100) begin
            n_err++;
            $display("FAIL post_reset_winner: got %b want 0100", grant);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_all_held();
        int k;
        logic [N-1:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        len = '0;
        req = 4'b1111;
        k = cyc;
        for (int j = 0; j < 5; j++) exp_q.push_back('{order[j], k + 2 + 3 * j});
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            n_cmp++;
            if (grant !== order[j]) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got %b want %b", j, grant, order[j]);
            end
            repeat (2) @(negedge clk);
        end
        req = '0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rr_stop: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_max_len();
        int k;
        set_len(0, 8'd255);
        req = 4'b0001;
        k = cyc;
        exp_q.push_back('{4'b0001, k + 257});
        @(negedge clk);
        req = '0;
        n_cmp++;
        if (grant !== 4'b0001 || count !== '0) begin
            n_err++;
            $display("FAIL max_grant: got grant=%b count=%0d, want 0001 0", grant, count);
        end
        repeat (255) @(negedge clk);
        n_cmp++;
        if (count !== 8'd255 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL max_top: got count=%0d busy=%b, want 255 1", count, busy);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (count !== 8'd255 || busy !== 1'b0 || grant !== '0) begin
            n_err++;
            $display("FAIL max_nowrap: got count=%0d busy=%b grant=%b, want 255 0 0000",
                     count, busy, grant);
        end
    endtask

    task automatic test_abort();
        int k;
        bit hit;
        set_len(1, 8'd10);
        req = 4'b0010;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req = '0;
            if (busy === 1'b1 && count === 8'd4) begin
                hit = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!hit || grant !== 4'b0010) begin
            n_err++;
            $display("FAIL abort_setup: got count=%0d grant=%b, want 4 0010", count, grant);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || grant !== '0 || count !== 8'd4) begin
            n_err++;
            $display("FAIL abort_exit: got busy=%b grant=%b count=%0d, want 0 0000 4",
                     busy, grant, count);
        end
        repeat (12) @(negedge clk);
        n_cmp++;
        if (count !== 8'd4) begin
            n_err++;
            $display("FAIL abort_hold: got count=%0d want 4", count);
        end
        len = '0;
        req = 4'b1111;
        k = cyc;
        exp_q.push_back('{4'b0100, k + 2});
        @(negedge clk);
        req = '0;
        n_cmp++;
        if (grant !== 4'b0100) begin
            n_err++;
            $display("FAIL abort_rotate: got %b want 0100", grant);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_len_change();
        int k;
        set_len(3, 8'd5);
        req = 4'b1000;
        k = cyc;
        exp_q.push_back('{4'b1000, k + 7});
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b1000) begin
            n_err++;
            $display("FAIL lenchg_grant: got %b want 1000", grant);
        end
        req = '0;
        set_len(3, 8'd1);
        repeat (6) @(negedge clk);
        n_cmp++;
        if (count !== 8'd5 || grant !== 4'b1000) begin
            n_err++;
            $display("FAIL lenchg_final: got count=%0d grant=%b, want 5 1000", count, grant);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL lenchg_idle: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_len_zero();
        test_reset_mid_run();
        test_all_held();
        test_max_len();
        test_abort();
        test_len_change();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_done: got %0d pending expected pulses, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
